// File: rtl/DataType.sv
// Shared SRAM port payloads and VGA line-fetcher state encoding.
package DataType;

    localparam int unsigned SRAM_ADDR_WIDTH = 20;
    localparam int unsigned SRAM_DATA_WIDTH = 16;

    typedef struct packed {
        logic                       oe_n;
        logic                       we_n;
        logic                       den;
        logic [SRAM_DATA_WIDTH-1:0] dout;
        logic [SRAM_ADDR_WIDTH-1:0] address;
    } SramRequest_t;

    typedef struct packed {
        logic                       done;
        logic [SRAM_DATA_WIDTH-1:0] din;
    } SramResult_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } vga_fetch_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned clampWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         headData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [CW-1:0]    countNext;
    logic             doPush;
    logic             doPop;

    // A push into a full FIFO is only accepted alongside a pop.
    always_comb begin
        doPop     = pop && !empty;
        doPush    = push && (!full || doPop);
        countNext = count + CW'(doPush) - CW'(doPop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            count <= countNext;
            empty <= (countNext == '0);
            full  <= (countNext == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr] <= pushData;
    end

    assign headData = mem[rdPtr];

endmodule

// File: rtl/vga_line_fetcher.sv
// Walks the framebuffer line by line over the SRAM VGA port into a pixel FIFO.
// LINE_DOUBLE_EN: fetch every line twice before advancing (scan doubling).
module vga_line_fetcher
    import DataType::*;
#(
    parameter int unsigned ADDR_WIDTH  = SRAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = SRAM_DATA_WIDTH,
    parameter int unsigned H_WORDS     = 320,
    parameter int unsigned V_LINES     = 240,
    parameter int unsigned LINE_STRIDE = 320,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [ADDR_WIDTH-1:0] fb_base,
    output SramRequest_t          vgaRequest,
    input  SramResult_t           vgaResult,
    input  logic                  pix_ready,
    output logic                  pix_valid,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  frame_done,
    output logic                  underflow
);

`ifdef LINE_DOUBLE_EN
    localparam bit DOUBLE = 1'b1;
`else
    localparam bit DOUBLE = 1'b0;
`endif

    localparam int unsigned XW = clampWidth(H_WORDS);
    localparam int unsigned YW = clampWidth(V_LINES);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    vga_fetch_state_t      state, stateNext;
    logic [XW-1:0]         x, xNext, selX;
    logic [YW-1:0]         y, yNext, selY;
    logic [ADDR_WIDTH-1:0] lineBase, baseNext, selBase;
    logic [ADDR_WIDTH-1:0] nextAddr, addrNext, selAddr;
    logic                  copy, copyNext, selCopy;
    logic                  discard, discardNext;
    logic                  tagReq, tagReqNext, tagResp;
    logic                  frameDoneNext, underflowNext;
    SramRequest_t          reqNext;

    logic                  push, pop, issue, room;
    logic                  lastX, lastLine, lastCopy;
    logic [CW:0]           occupancy;
    logic [CW-1:0]         fifoCount;
    logic                  fifoEmpty, fifoFull;

    assign pix_valid = !fifoEmpty;

    // frame_start restarts the walk from fb_base and issues its first read immediately.
    always_comb begin
        stateNext     = state;
        xNext         = x;
        yNext         = y;
        baseNext      = lineBase;
        addrNext      = nextAddr;
        copyNext      = copy;
        discardNext   = discard;
        tagReqNext    = 1'b0;
        reqNext       = vgaRequest;
        reqNext.oe_n  = 1'b1;
        reqNext.we_n  = 1'b1;
        reqNext.den   = 1'b0;
        reqNext.dout  = '0;
        underflowNext = underflow || (pix_ready && !pix_valid);

        push = vgaResult.done && !discard && !frame_start;
        pop  = pix_valid && pix_ready;
        frameDoneNext = push && tagResp;

        // Reads still owed to the FIFO: the one on the bus now and the one returning now.
        occupancy = (CW+1)'(fifoCount) + (CW+1)'(!vgaRequest.oe_n)
                  + (CW+1)'(vgaResult.done && !discard) + (CW+1)'(1);
        room      = !fifoFull && (occupancy <= (CW+1)'(FIFO_DEPTH));
        issue     = frame_start || ((state == FETCH) && room);

        selX     = frame_start ? '0 : x;
        selY     = frame_start ? '0 : y;
        selCopy  = frame_start ? 1'b0 : copy;
        selBase  = frame_start ? fb_base : lineBase;
        selAddr  = frame_start ? fb_base : nextAddr;
        lastX    = (selX == XW'(H_WORDS - 1));
        lastLine = (selY == YW'(V_LINES - 1));
        lastCopy = !DOUBLE || selCopy;

        if (issue) begin
            reqNext.oe_n    = 1'b0;
            reqNext.address = SRAM_ADDR_WIDTH'(selAddr);
            tagReqNext      = lastX && lastLine && lastCopy;
            yNext           = selY;
            baseNext        = selBase;
            copyNext        = selCopy;
            if (!lastX) begin
                xNext    = selX + XW'(1);
                addrNext = selAddr + ADDR_WIDTH'(1);
            end else if (DOUBLE && !selCopy) begin
                xNext    = '0;
                copyNext = 1'b1;
                addrNext = selBase;
            end else begin
                xNext    = '0;
                copyNext = 1'b0;
                yNext    = selY + YW'(1);
                baseNext = selBase + ADDR_WIDTH'(LINE_STRIDE);
                addrNext = selBase + ADDR_WIDTH'(LINE_STRIDE);
            end
        end

        if (frame_start) begin
            discardNext   = !vgaRequest.oe_n;
            underflowNext = 1'b0;
        end else if (vgaResult.done && discard) begin
            discardNext = 1'b0;
        end

        case (state)
            FETCH:   if (issue && tagReqNext) stateNext = DONE;
            DONE:    if (push && tagResp) stateNext = IDLE;
            default: stateNext = state;
        endcase
        if (frame_start) stateNext = tagReqNext ? DONE : FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            lineBase   <= '0;
            nextAddr   <= '0;
            copy       <= 1'b0;
            discard    <= 1'b0;
            tagReq     <= 1'b0;
            tagResp    <= 1'b0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
            vgaRequest <= '{oe_n: 1'b1, we_n: 1'b1, den: 1'b0, dout: '0, address: '0};
        end else begin
            state      <= stateNext;
            x          <= xNext;
            y          <= yNext;
            lineBase   <= baseNext;
            nextAddr   <= addrNext;
            copy       <= copyNext;
            discard    <= discardNext;
            tagReq     <= tagReqNext;
            tagResp    <= tagReq;
            frame_done <= frameDoneNext;
            underflow  <= underflowNext;
            vgaRequest <= reqNext;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) pixelFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (frame_start),
        .push     (push),
        .pushData (DATA_WIDTH'(vgaResult.din)),
        .pop      (pop),
        .headData (pix_data),
        .count    (fifoCount),
        .empty    (fifoEmpty),
        .full     (fifoFull)
    );

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Directed bench for vga_line_fetcher with a one-cycle-latency SRAM model.
module tb_vga_line_fetcher;
    import DataType::*;

    localparam int unsigned H     = 4;
    localparam int unsigned V     = 6;
    localparam int unsigned S     = 8;
    localparam int unsigned DEPTH = 16;
`ifdef LINE_DOUBLE_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif
    localparam int unsigned NREADS = H * V * (DBL ? 2 : 1);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         frame_start;
    logic [19:0]  fb_base;
    SramRequest_t vgaRequest;
    SramResult_t  ctrlResult;
    logic         pix_ready;
    logic         pix_valid;
    logic [15:0]  pix_data;
    logic         frame_done;
    logic         underflow;
    logic         follow;
    logic         manualReady;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fdCnt = 0;
    int fdCyc = -1;
    int protoErr = 0;
    logic [19:0] readQ[$];
    int          readCyc[$];
    logic [15:0] popQ[$];

    typedef struct {
        logic [19:0] base;
        logic [19:0] a0;
        logic [19:0] a3;
        logic [19:0] a4;
        logic [19:0] aLast;
    } vec_t;
    vec_t vecs[4];

    initial forever #5 clk = ~clk;

    assign pix_ready = follow ? pix_valid : manualReady;

    vga_line_fetcher #(
        .H_WORDS     (H),
        .V_LINES     (V),
        .LINE_STRIDE (S),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .fb_base     (fb_base),
        .vgaRequest  (vgaRequest),
        .vgaResult   (ctrlResult),
        .pix_ready   (pix_ready),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .frame_done  (frame_done),
        .underflow   (underflow)
    );

    function automatic logic [15:0] dataOf(input logic [19:0] a);
        return a[15:0] ^ {12'h000, a[19:16]} ^ 16'h5A3C;
    endfunction

    function automatic logic [19:0] model(input logic [19:0] b, input int k);
        int line;
        int xk;
        line = DBL ? k / int'(2 * H) : k / int'(H);
        xk   = k % int'(H);
        return b + 20'(line * int'(S) + xk);
    endfunction

    function automatic logic [19:0] readAt(input int i);
        if (i >= 0 && i < readQ.size()) return readQ[i];
        return 'x;
    endfunction

    function automatic logic [15:0] popAt(input int i);
        if (i >= 0 && i < popQ.size()) return popQ[i];
        return 'x;
    endfunction

    function automatic int cycAt(input int i);
        if (i >= 0 && i < readCyc.size()) return readCyc[i];
        return -1000;
    endfunction

    // SRAM controller: done and data exactly one cycle after the request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrlResult <= '0;
        end else begin
            ctrlResult.done <= !vgaRequest.oe_n;
            ctrlResult.din  <= dataOf(vgaRequest.address);
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!vgaRequest.oe_n) begin
            readQ.push_back(vgaRequest.address);
            readCyc.push_back(cyc);
        end
        if (pix_valid && pix_ready) popQ.push_back(pix_data);
        if (frame_done) begin
            fdCnt <= fdCnt + 1;
            fdCyc <= cyc;
        end
        if (vgaRequest.we_n !== 1'b1 || vgaRequest.den !== 1'b0 || vgaRequest.dout !== '0)
            protoErr <= protoErr + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finishFrame(input logic [19:0] base, input int rIdx, input int pIdx,
                               input int fdStart, input bit contig);
        bit ok = 1'b0;
        int mis = 0;
        int pmis = 0;
        for (int i = 0; i < 400; i++) begin
            if (fdCnt > fdStart && popQ.size() - pIdx >= int'(NREADS)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("frame complete", 64'(ok), 64'(1));
        repeat (6) tick();
        check("read count", 64'(readQ.size() - rIdx), 64'(NREADS));
        for (int k = 0; k < int'(NREADS); k++) begin
            if (readAt(rIdx + k) !== model(base, k)) mis++;
            if (popAt(pIdx + k) !== dataOf(model(base, k))) pmis++;
        end
        check("address walk", 64'(mis), 64'(0));
        check("pop count", 64'(popQ.size() - pIdx), 64'(NREADS));
        check("pop data", 64'(pmis), 64'(0));
        check("frame_done pulses", 64'(fdCnt - fdStart), 64'(1));
        check("frame_done timing", 64'(fdCyc), 64'(cycAt(rIdx + int'(NREADS) - 1) + 2));
        if (contig)
            check("back-to-back", 64'(cycAt(rIdx + int'(NREADS) - 1) - cycAt(rIdx)), 64'(NREADS - 1));
        check("no underflow", 64'(underflow), 64'(0));
        check("fifo drained", 64'(pix_valid), 64'(0));
    endtask

    task automatic runFrame(input vec_t v);
        int rIdx, pIdx, fdStart;
        follow      = 1'b1;
        fb_base     = v.base;
        frame_start = 1'b1;
        rIdx    = readQ.size();
        pIdx    = popQ.size();
        fdStart = fdCnt;
        tick();
        frame_start = 1'b0;
        check("underflow cleared", 64'(underflow), 64'(0));
        check("valid +1", 64'(pix_valid), 64'(0));
        tick();
        check("valid +2 edge-1", 64'(pix_valid), 64'(0));
        tick();
        check("valid +2", 64'(pix_valid), 64'(1));
        finishFrame(v.base, rIdx, pIdx, fdStart, 1'b1);
        check("addr[0]", 64'(readAt(rIdx)), 64'(v.a0));
        check("addr[3]", 64'(readAt(rIdx + 3)), 64'(v.a3));
        check("addr[4]", 64'(readAt(rIdx + 4)), 64'(v.a4));
        check("addr[last]", 64'(readAt(rIdx + int'(NREADS) - 1)), 64'(v.aLast));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        SramRequest_t rstReq;
        int rIdx, pIdx, fdStart;
        rstReq = '{oe_n: 1'b1, we_n: 1'b1, den: 1'b0, dout: '0, address: '0};

        vecs[0] = '{20'h01000, 20'h01000, 20'h01003, DBL ? 20'h01000 : 20'h01008, 20'h0102B};
        vecs[1] = '{20'h00000, 20'h00000, 20'h00003, DBL ? 20'h00000 : 20'h00008, 20'h0002B};
        vecs[2] = '{20'hFFFF6, 20'hFFFF6, 20'hFFFF9, DBL ? 20'hFFFF6 : 20'hFFFFE, 20'h00021};
        vecs[3] = '{20'h12345, 20'h12345, 20'h12348, DBL ? 20'h12345 : 20'h1234D, 20'h12370};

        rst_n = 1'b0;
        frame_start = 1'b0;
        fb_base = '0;
        follow = 1'b0;
        manualReady = 1'b0;
        repeat (3) tick();
        check("reset request", 64'(vgaRequest), 64'(rstReq));
        check("reset pix_valid", 64'(pix_valid), 64'(0));
        check("reset frame_done", 64'(frame_done), 64'(0));
        check("reset underflow", 64'(underflow), 64'(0));
        rst_n = 1'b1;
        tick();

        // Pop attempt with no frame running.
        manualReady = 1'b1;
        tick();
        manualReady = 1'b0;
        check("underflow set", 64'(underflow), 64'(1));
        repeat (5) tick();
        check("underflow sticky", 64'(underflow), 64'(1));
        check("underflow no data", 64'(pix_valid), 64'(0));
        check("idle no reads", 64'(readQ.size()), 64'(0));

        for (int i = 0; i < 4; i++) runFrame(vecs[i]);

        // Stalled consumer: FIFO fills, then one pop buys one read.
        follow = 1'b0;
        manualReady = 1'b0;
        rIdx = readQ.size();
        pIdx = popQ.size();
        fdStart = fdCnt;
        fb_base = 20'h20000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (40) tick();
        check("stall reads", 64'(readQ.size() - rIdx), 64'(DEPTH));
        check("stall oe_n", 64'(vgaRequest.oe_n), 64'(1));
        check("stall head", 64'(pix_data), 64'(dataOf(20'h20000)));
        manualReady = 1'b1;
        tick();
        manualReady = 1'b0;
        repeat (10) tick();
        check("one pop one read", 64'(readQ.size() - rIdx), 64'(DEPTH + 1));
        check("head after pop", 64'(pix_data), 64'(dataOf(20'h20001)));
        follow = 1'b1;
        finishFrame(20'h20000, rIdx, pIdx, fdStart, 1'b0);

        // Restart the cycle after a read issue: old returns are dropped.
        follow = 1'b0;
        manualReady = 1'b0;
        fb_base = 20'h30000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        fb_base = 20'h40000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        rIdx = readQ.size();
        pIdx = popQ.size();
        fdStart = fdCnt;
        check("abort empty +1", 64'(pix_valid), 64'(0));
        tick();
        check("abort empty +2", 64'(pix_valid), 64'(0));
        tick();
        check("abort first valid", 64'(pix_valid), 64'(1));
        check("abort first data", 64'(pix_data), 64'(dataOf(20'h40000)));
        check("abort first addr", 64'(readAt(rIdx)), 64'(20'h40000));
        follow = 1'b1;
        finishFrame(20'h40000, rIdx, pIdx, fdStart, 1'b0);

        // Asynchronous reset in the middle of a frame.
        follow = 1'b1;
        fb_base = 20'h50000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async reset request", 64'(vgaRequest), 64'(rstReq));
        check("async reset valid", 64'(pix_valid), 64'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        rIdx = readQ.size();
        fdStart = fdCnt;
        repeat (30) tick();
        check("idle after reset", 64'(readQ.size() - rIdx), 64'(0));
        check("no frame_done after reset", 64'(fdCnt - fdStart), 64'(0));
        check("request invariants", 64'(protoErr), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
